uart_rx: RTL and testbench

Oversampling UART receiver: recovers 8-bit frames from a serial line with an optional parity bit, oversampled by a runtime prescale factor. Sits between the serial input pin and the parallel consumer logic. A frame passes only if it has a valid start bit, a correct parity bit (when enabled) and a valid stop bit. Passed frames appear on `P_DATA` with `data_valid` asserted.

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Parallel-side and serial-side signals of the oversampling UART receiver.
// The master drives configuration and the serial line; the slave (receiver) returns the byte.
interface uart_rx_if;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       RX_IN;
    logic [7:0] P_DATA;
    logic       data_valid;

    modport master (
        output PAR_EN, PAR_TYP, Prescale, RX_IN,
        input  P_DATA, data_valid
    );

    modport slave (
        input  PAR_EN, PAR_TYP, Prescale, RX_IN,
        output P_DATA, data_valid
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, optional even/odd parity, runtime prescale.
// Each bit is decided by a 2-of-3 majority around mid-bit; good frames load P_DATA and raise data_valid.
module uart_rx (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_edge_cnt;
    logic [5:0] r_prescale;
    logic [2:0] r_bit_cnt;
    logic       r_par_en;
    logic       r_par_typ;
    logic       r_s0;
    logic       r_s1;
    logic       r_maj;
    logic       r_par_err;
    logic [7:0] r_shift;
    logic [7:0] r_p_data;
    logic       r_data_valid;

    logic [5:0] w_half;
    logic       w_bit_end;
    logic       w_act;
    logic       w_par_exp;

    assign w_half    = {1'b0, r_prescale[5:1]};
    assign w_bit_end = (r_edge_cnt == r_prescale - 6'd1);
    // The majority is registered at edge P/2+1, so it is acted on one edge later.
    assign w_act     = (r_edge_cnt == w_half + 6'd2);
    assign w_par_exp = (^r_shift) ^ r_par_typ;

    assign bus.P_DATA     = r_p_data;
    assign bus.data_valid = r_data_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!bus.RX_IN) w_state_next = S_START;
            end
            S_START: begin
                if (w_act && r_maj)  w_state_next = S_IDLE;
                else if (w_bit_end)  w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == 3'd7))
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                // Leave early so a back-to-back start edge is caught in the tail of the stop bit.
                if (w_act) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt   <= 6'd0;
            r_prescale   <= 6'd0;
            r_bit_cnt    <= 3'd0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_maj        <= 1'b0;
            r_par_err    <= 1'b0;
            r_shift      <= 8'h00;
            r_p_data     <= 8'h00;
            r_data_valid <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= 3'd0;
            if (!bus.RX_IN) begin
                // This posedge is edge 0 of the start bit.
                r_edge_cnt   <= 6'd1;
                r_prescale   <= bus.Prescale;
                r_par_en     <= bus.PAR_EN;
                r_par_typ    <= bus.PAR_TYP;
                r_par_err    <= 1'b0;
                r_data_valid <= 1'b0;
            end
        end else begin
            r_edge_cnt <= w_bit_end ? 6'd0 : r_edge_cnt + 6'd1;
            if (r_edge_cnt == w_half - 6'd1) r_s0 <= bus.RX_IN;
            if (r_edge_cnt == w_half)        r_s1 <= bus.RX_IN;
            if (r_edge_cnt == w_half + 6'd1)
                r_maj <= (r_s0 & r_s1) | (r_s0 & bus.RX_IN) | (r_s1 & bus.RX_IN);
            if ((r_state == S_DATA) && w_bit_end) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_act) begin
                case (r_state)
                    S_DATA:   r_shift <= {r_maj, r_shift[7:1]};
                    S_PARITY: if (r_maj != w_par_exp) r_par_err <= 1'b1;
                    S_STOP: begin
                        if (r_maj && !r_par_err) begin
                            r_p_data     <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed test-plan frames followed by randomized frames,
// checked against a frame-level model (good frame -> byte appears, otherwise previous byte kept).
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_if u_if ();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_parity(input logic [7:0] d, input bit odd);
        int ones;
        ones = $countones(d);
        return ((ones % 2) == 1) ^ odd;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; bit windows start on the posedge after RX_IN changes.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit bad_par, input bit stop_bit);
        bit good;
        bit pbit;
        u_if.Prescale = p[5:0];
        u_if.PAR_EN   = pen;
        u_if.PAR_TYP  = ptyp;
        pbit = ref_parity(d, ptyp) ^ bad_par;
        good = stop_bit && (!pen || !bad_par);

        u_if.RX_IN = 1'b0;
        tick();
        exp_valid = 1'b0;
        check("start_clears_valid", u_if.data_valid, exp_valid);
        repeat (p - 1) tick();
        for (int i = 0; i < 8; i++) begin
            u_if.RX_IN = d[i];
            repeat (p) tick();
        end
        if (pen) begin
            u_if.RX_IN = pbit;
            repeat (p) tick();
        end
        u_if.RX_IN = stop_bit;
        for (int e = 0; e < p; e++) begin
            tick();
            if (e == p / 2 + 1) begin
                check("pre_decision_valid", u_if.data_valid, exp_valid);
                check("pre_decision_data", u_if.P_DATA, exp_data);
            end
            if (e == p / 2 + 2) begin
                if (good) begin
                    exp_data  = d;
                    exp_valid = 1'b1;
                end
                check("frame_data", u_if.P_DATA, exp_data);
                check("frame_valid", u_if.data_valid, exp_valid);
                u_if.RX_IN = 1'b1;
            end
        end
        check("end_of_stop_valid", u_if.data_valid, exp_valid);
        $display("frame byte=%02h P=%0d par_en=%0d par_typ=%0d bad_par=%0d stop=%0d -> P_DATA=%02h data_valid=%0d",
                 d, p, pen, ptyp, bad_par, stop_bit, u_if.P_DATA, u_if.data_valid);
    endtask

    task automatic glitch(input int p, input int len);
        u_if.Prescale = p[5:0];
        u_if.RX_IN = 1'b0;
        repeat (len) tick();
        exp_valid = 1'b0;
        u_if.RX_IN = 1'b1;
        repeat (2 * p) tick();
        check("glitch_valid", u_if.data_valid, exp_valid);
        check("glitch_data", u_if.P_DATA, exp_data);
        $display("glitch len=%0d P=%0d -> P_DATA=%02h data_valid=%0d", len, p, u_if.P_DATA, u_if.data_valid);
    endtask

    task automatic idle(input int n);
        u_if.RX_IN = 1'b1;
        repeat (n) tick();
        check("idle_valid", u_if.data_valid, exp_valid);
        check("idle_data", u_if.P_DATA, exp_data);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        bit pen, ptyp, bad_par, stop_bit;
        logic [7:0] d;

        rst = 1'b1;
        u_if.RX_IN    = 1'b1;
        u_if.PAR_EN   = 1'b0;
        u_if.PAR_TYP  = 1'b0;
        u_if.Prescale = 6'd8;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", u_if.P_DATA, exp_data);
        check("reset_valid", u_if.data_valid, exp_valid);
        rst = 1'b0;
        idle(5);

        send_frame(8'h45, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA8, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'hAA, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        glitch(8, 2);
        send_frame(8'hF0, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h0F, 32, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a frame aborts it and clears the outputs.
        u_if.Prescale = 6'd16;
        u_if.RX_IN = 1'b0;
        repeat (40) tick();
        rst = 1'b1;
        #1;
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        check("midframe_reset_data", u_if.P_DATA, exp_data);
        check("midframe_reset_valid", u_if.data_valid, exp_valid);
        u_if.RX_IN = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle(4);
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            p        = 8 << $urandom_range(0, 2);
            d        = 8'($urandom);
            pen      = 1'($urandom_range(0, 1));
            ptyp     = 1'($urandom_range(0, 1));
            bad_par  = ($urandom_range(0, 4) == 0);
            stop_bit = ($urandom_range(0, 5) != 0);
            send_frame(d, p, pen, ptyp, bad_par, stop_bit);
            case ($urandom_range(0, 5))
                0: glitch(p, $urandom_range(1, p / 2 - 2));
                1: idle($urandom_range(1, 3 * p));
                default: ;
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
